// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter.
//   - arbiter FSM state encodings (ARB_IDLE=0, ARB_AR=1, ARB_R=2)
//   - grant owner encoding
//   - default AXI IDs for the fetch and load requesters
//   - AXI burst type constant
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbAr   = 2'd1,
    ArbR    = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntInst = 1'b0,
    GntData = 1'b1
  } grant_e;

  localparam logic [3:0] DEF_INST_ID    = 4'd0;
  localparam logic [3:0] DEF_DATA_ID    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  // Fetches are always full 32-bit words.
  localparam logic [2:0] INST_SIZE      = 3'd2;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI read arbiter shared by instruction fetch and data load.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   flush                  pipeline redirect; cancels a pending or in-flight fetch
//   inst_req_*             fetch request (valid/addr in, ready pulse out)
//   inst_rvalid/rdata      fetch response (1-cycle pulse, combinational from the R beat)
//   data_req_*             load request (valid/addr/size in, ready pulse out)
//   data_rvalid/rdata      load response (1-cycle pulse, combinational from the R beat)
//   ar*, r*                AXI read address and read data channels (single-beat INCR)
//
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration between
// simultaneous requests; when undefined, loads have fixed priority over fetches.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [3:0]  INST_ID = DEF_INST_ID,
  parameter logic [3:0]  DATA_ID = DEF_DATA_ID
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inst_req_valid,
  input  logic [ADDR_W-1:0] inst_req_addr,
  output logic              inst_req_ready,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req_valid,
  input  logic [ADDR_W-1:0] data_req_addr,
  input  logic [2:0]        data_req_size,
  output logic              data_req_ready,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  arb_state_e        state_q, state_d;
  grant_e            grant_q, grant_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        id_q, id_d;
  logic [2:0]        size_q, size_d;

  logic inst_elig;
  logic pick_data;
  logic beat_done;

  // A flush in IDLE only suppresses the fetch grant for that cycle.
  assign inst_elig = inst_req_valid & ~flush;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e last_q, last_d;
  assign pick_data = data_req_valid & (~inst_elig | (last_q == GntInst));
`else
  assign pick_data = data_req_valid;
`endif

  // Beats carrying a foreign ID are ignored: no response and no state change.
  assign beat_done = (state_q == ArbR) & rvalid & rlast & (rid == id_q);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    drop_d         = drop_q;
    addr_d         = addr_q;
    id_d           = id_q;
    size_d         = size_q;
    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d         = last_q;
`endif
    unique case (state_q)
      ArbIdle: begin
        // Ready is combinational, so it must stay low while reset is held.
        if (!reset && (pick_data || inst_elig)) begin
          state_d = ArbAr;
          drop_d  = 1'b0;
          if (pick_data) begin
            grant_d        = GntData;
            addr_d         = data_req_addr;
            size_d         = data_req_size;
            id_d           = DATA_ID;
            data_req_ready = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d         = GntData;
`endif
          end else begin
            grant_d        = GntInst;
            addr_d         = inst_req_addr;
            size_d         = INST_SIZE;
            id_d           = INST_ID;
            inst_req_ready = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d         = GntInst;
`endif
          end
        end
      end
      ArbAr: begin
        if (flush && (grant_q == GntInst)) drop_d = 1'b1;
        if (arready) state_d = ArbR;
      end
      ArbR: begin
        if (flush && (grant_q == GntInst)) drop_d = 1'b1;
        if (beat_done) begin
          state_d = ArbIdle;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ArbIdle;
      grant_q <= GntInst;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      size_q  <= size_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) last_q <= GntInst;
    else       last_q <= last_d;
  end
`endif

  assign arvalid = (state_q == ArbAr);
  assign rready  = (state_q == ArbR);
  assign araddr  = addr_q;
  assign arid    = id_q;
  assign arsize  = size_q;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;

  assign data_rvalid = beat_done & (grant_q == GntData);
  // A flush in the same cycle as the beat also kills the fetch response.
  assign inst_rvalid = beat_done & (grant_q == GntInst) & ~drop_q & ~flush;
  assign data_rdata  = rdata;
  assign inst_rdata  = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: acts as the AXI slave and both
// requesters; expected AR beats and responses are queued on each request.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        inst_req_valid = 1'b0;
  logic [31:0] inst_req_addr = '0;
  logic        inst_req_ready;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req_valid = 1'b0;
  logic [31:0] data_req_addr = '0;
  logic [2:0]  data_req_size = '0;
  logic        data_req_ready;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic        is_data;
    logic        drop;
    logic [31:0] data;
  } r_t;

  ar_t exp_ar[$];
  r_t  exp_r[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mdl_last_data = 1'b0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .inst_req_valid (inst_req_valid),
    .inst_req_addr  (inst_req_addr),
    .inst_req_ready (inst_req_ready),
    .inst_rvalid    (inst_rvalid),
    .inst_rdata     (inst_rdata),
    .data_req_valid (data_req_valid),
    .data_req_addr  (data_req_addr),
    .data_req_size  (data_req_size),
    .data_req_ready (data_req_ready),
    .data_rvalid    (data_rvalid),
    .data_rdata     (data_rdata),
    .arid           (arid),
    .araddr         (araddr),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .arvalid        (arvalid),
    .arready        (arready),
    .rid            (rid),
    .rdata          (rdata),
    .rlast          (rlast),
    .rvalid         (rvalid),
    .rready         (rready)
  );

  // Protocol monitor: the slave must answer with the ID of the outstanding read.
  always @(posedge clk) begin
    if (!reset && rvalid && rready) begin
      assert (rid == arid) else $error("rid %0h differs from arid %0h", rid, arid);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Serves one read starting in the AR cycle: arready after ar_wait stall
  // cycles, rvalid after r_wait cycles in R. flush_at=-2 holds flush
  // throughout, otherwise flush pulses in R cycle flush_at.
  task automatic do_axi(input int ar_wait, input int r_wait, input logic [31:0] d,
                        input int flush_at, output ar_t o_ar, output bit o_stable,
                        output bit o_rready, output int n_inst, output int n_data,
                        output logic [31:0] o_rdata);
    o_ar = '0; o_stable = 1'b1; o_rready = 1'b1;
    n_inst = 0; n_data = 0; o_rdata = '0;
    for (int i = 0; i <= ar_wait; i++) begin
      arready = (i == ar_wait);
      flush   = (flush_at == -2);
      #1;
      if (i == 0) o_ar = '{id: arid, addr: araddr, size: arsize};
      else if (o_ar != {arid, araddr, arsize}) o_stable = 1'b0;
      if (!arvalid) o_stable = 1'b0;
      cyc();
    end
    arready = 1'b0;
    for (int i = 0; i <= r_wait; i++) begin
      rvalid = (i == r_wait);
      rid    = o_ar.id;
      rdata  = d;
      rlast  = 1'b1;
      flush  = (flush_at == -2) || (i == flush_at);
      #1;
      if (!rready) o_rready = 1'b0;
      if (inst_rvalid) begin n_inst++; o_rdata = inst_rdata; end
      if (data_rvalid) begin n_data++; o_rdata = data_rdata; end
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0; flush = 1'b0; rdata = '0;
  endtask

  task automatic pop_exp(output ar_t a, output r_t r, output bit ok);
    ok = (exp_ar.size() > 0) && (exp_r.size() > 0);
    a = '0; r = '0;
    if (ok) begin
      a = exp_ar.pop_front();
      r = exp_r.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_req_valid = 1'b1; data_req_valid = 1'b1;
    inst_req_addr = 32'h1234_5678; data_req_addr = 32'h8765_4321;
    rvalid = 1'b1; rlast = 1'b1; arready = 1'b1;
    repeat (2) cyc();
    #1;
    n_checks++;
    if ({arvalid, rready, inst_req_ready, data_req_ready, inst_rvalid, data_rvalid} !== 6'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {arvalid, rready, inst_req_ready, data_req_ready, inst_rvalid, data_rvalid}); end
    n_checks++;
    if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h want 0", araddr); end
    n_checks++;
    if ({arid, arsize} !== 7'h0)
      begin n_fail++; $display("FAIL reset_id_size: got %h/%h want 0/0", arid, arsize); end
    n_checks++;
    if ({arlen, arburst} !== {8'd0, 2'b01})
      begin n_fail++; $display("FAIL reset_len_burst: got %h/%b want 00/01", arlen, arburst); end
    reset = 1'b0; inst_req_valid = 1'b0; data_req_valid = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    exp_ar.delete(); exp_r.delete(); mdl_last_data = 1'b0;
    cyc();
  endtask

  task automatic test_single_fetch();
    ar_t oa, ea; r_t er; bit ok, st, rr; int ni, nd; logic [31:0] od;
    inst_req_valid = 1'b1; inst_req_addr = 32'hBFC0_0000;
    #1;
    n_checks++;
    if ({inst_req_ready, data_req_ready} !== 2'b10)
      begin n_fail++; $display("FAIL fetch_ready: got %b want 10", {inst_req_ready, data_req_ready}); end
    exp_ar.push_back('{id: 4'd0, addr: 32'hBFC0_0000, size: 3'd2});
    exp_r.push_back('{is_data: 1'b0, drop: 1'b0, data: 32'h2408_0001});
    mdl_last_data = 1'b0;
    cyc();
    inst_req_valid = 1'b0;
    do_axi(2, 1, 32'h2408_0001, -1, oa, st, rr, ni, nd, od);
    pop_exp(ea, er, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL fetch_sb: got empty queue want entry"); end
    n_checks++;
    if (oa !== ea) begin n_fail++; $display("FAIL fetch_ar: got %h want %h", oa, ea); end
    n_checks++;
    if (ni != 1 || nd != 0)
      begin n_fail++; $display("FAIL fetch_rvalid: got %0d/%0d want 1/0", ni, nd); end
    n_checks++;
    if (od !== er.data) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", od, er.data); end
    n_checks++;
    if (!st || !rr) begin n_fail++; $display("FAIL fetch_hs: got %b%b want 11", st, rr); end
    #1;
    n_checks++;
    if ({arvalid, rready, inst_req_ready} !== 3'b000)
      begin n_fail++; $display("FAIL fetch_idle: got %b want 000", {arvalid, rready, inst_req_ready}); end
  endtask

  // Both requesters in the same IDLE cycle; the loser keeps its request up
  // and must be granted in the first IDLE cycle after the winner's rlast.
  task automatic test_simultaneous(input logic [31:0] ia, input logic [31:0] da,
                                   input logic [31:0] idat, input logic [31:0] ddat);
    ar_t oa, ea; r_t er; bit ok, st, rr, win, cur; int ni, nd; logic [31:0] od;
`ifdef ARB_ROUND_ROBIN_EN
    win = !mdl_last_data;
`else
    win = 1'b1;
`endif
    inst_req_valid = 1'b1; inst_req_addr = ia;
    data_req_valid = 1'b1; data_req_addr = da; data_req_size = 3'd0;
    #1;
    n_checks++;
    if ({inst_req_ready, data_req_ready} !== {!win, win})
      begin n_fail++; $display("FAIL simul_first: got %b want %b",
        {inst_req_ready, data_req_ready}, {!win, win}); end
    for (int k = 0; k < 2; k++) begin
      cur = (k == 0) ? win : !win;
      if (k == 1) begin
        #1;
        n_checks++;
        if ({inst_req_ready, data_req_ready} !== {!cur, cur})
          begin n_fail++; $display("FAIL simul_second: got %b want %b",
            {inst_req_ready, data_req_ready}, {!cur, cur}); end
      end
      if (cur) exp_ar.push_back('{id: 4'd1, addr: da, size: 3'd0});
      else     exp_ar.push_back('{id: 4'd0, addr: ia, size: 3'd2});
      exp_r.push_back('{is_data: cur, drop: 1'b0, data: cur ? ddat : idat});
      mdl_last_data = cur;
      cyc();
      if (cur) data_req_valid = 1'b0;
      else     inst_req_valid = 1'b0;
      do_axi(0, 0, cur ? ddat : idat, -1, oa, st, rr, ni, nd, od);
      pop_exp(ea, er, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL simul_sb: got empty queue want entry"); end
      n_checks++;
      if (oa !== ea) begin n_fail++; $display("FAIL simul_ar%0d: got %h want %h", k, oa, ea); end
      n_checks++;
      if (ni != (er.is_data ? 0 : 1) || nd != (er.is_data ? 1 : 0))
        begin n_fail++; $display("FAIL simul_rvalid%0d: got %0d/%0d want %0d/%0d",
          k, ni, nd, er.is_data ? 0 : 1, er.is_data ? 1 : 0); end
      n_checks++;
      if (od !== er.data)
        begin n_fail++; $display("FAIL simul_rdata%0d: got %h want %h", k, od, er.data); end
    end
    #1;
    n_checks++;
    if ({arvalid, inst_req_ready, data_req_ready} !== 3'b000)
      begin n_fail++; $display("FAIL simul_idle: got %b want 000",
        {arvalid, inst_req_ready, data_req_ready}); end
  endtask

  task automatic test_ar_stall();
    ar_t oa, ea; r_t er; bit ok, st, rr; int ni, nd; logic [31:0] od;
    inst_req_valid = 1'b1; inst_req_addr = 32'hBFC0_0010;
    #1;
    n_checks++;
    if (inst_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b want 1", inst_req_ready); end
    exp_ar.push_back('{id: 4'd0, addr: 32'hBFC0_0010, size: 3'd2});
    exp_r.push_back('{is_data: 1'b0, drop: 1'b0, data: 32'h8C88_0004});
    mdl_last_data = 1'b0;
    cyc();
    inst_req_valid = 1'b0;
    do_axi(10, 3, 32'h8C88_0004, -1, oa, st, rr, ni, nd, od);
    pop_exp(ea, er, ok);
    n_checks++;
    if (!st) begin n_fail++; $display("FAIL stall_stable: got unstable AR want stable"); end
    n_checks++;
    if (!ok || oa !== ea) begin n_fail++; $display("FAIL stall_ar: got %h want %h", oa, ea); end
    n_checks++;
    if (ni != 1 || od !== er.data)
      begin n_fail++; $display("FAIL stall_resp: got %0d/%h want 1/%h", ni, od, er.data); end
  endtask

  task automatic test_data_flush();
    ar_t oa, ea; r_t er; bit ok, st, rr; int ni, nd; logic [31:0] od;
    flush = 1'b1;
    data_req_valid = 1'b1; data_req_addr = 32'h8000_0020; data_req_size = 3'd2;
    #1;
    n_checks++;
    if (data_req_ready !== 1'b1)
      begin n_fail++; $display("FAIL dflush_ready: got %b want 1", data_req_ready); end
    exp_ar.push_back('{id: 4'd1, addr: 32'h8000_0020, size: 3'd2});
    exp_r.push_back('{is_data: 1'b1, drop: 1'b0, data: 32'h1234_5678});
    mdl_last_data = 1'b1;
    cyc();
    data_req_valid = 1'b0;
    do_axi(1, 2, 32'h1234_5678, -2, oa, st, rr, ni, nd, od);
    pop_exp(ea, er, ok);
    n_checks++;
    if (!ok || oa !== ea) begin n_fail++; $display("FAIL dflush_ar: got %h want %h", oa, ea); end
    n_checks++;
    if (nd != 1 || ni != 0)
      begin n_fail++; $display("FAIL dflush_rvalid: got %0d/%0d want 0/1", ni, nd); end
    n_checks++;
    if (od !== er.data) begin n_fail++; $display("FAIL dflush_rdata: got %h want %h", od, er.data); end
  endtask

  task automatic test_fetch_flush();
    ar_t oa, ea; r_t er; bit ok, st, rr; int ni, nd; logic [31:0] od;
    inst_req_valid = 1'b1; inst_req_addr = 32'hBFC0_0100;
    #1;
    exp_ar.push_back('{id: 4'd0, addr: 32'hBFC0_0100, size: 3'd2});
    exp_r.push_back('{is_data: 1'b0, drop: 1'b1, data: 32'hDEAD_BEEF});
    mdl_last_data = 1'b0;
    cyc();
    inst_req_valid = 1'b0;
    // Flush lands one cycle before the beat.
    do_axi(1, 2, 32'hDEAD_BEEF, 1, oa, st, rr, ni, nd, od);
    pop_exp(ea, er, ok);
    n_checks++;
    if (!ok || oa !== ea) begin n_fail++; $display("FAIL fflush_ar: got %h want %h", oa, ea); end
    n_checks++;
    if (!rr) begin n_fail++; $display("FAIL fflush_rready: got 0 want 1 during R"); end
    n_checks++;
    if (ni != (er.drop ? 0 : 1) || nd != 0)
      begin n_fail++; $display("FAIL fflush_rvalid: got %0d/%0d want 0/0", ni, nd); end
    inst_req_valid = 1'b1; inst_req_addr = 32'hBFC0_0380;
    #1;
    n_checks++;
    if (inst_req_ready !== 1'b1)
      begin n_fail++; $display("FAIL fflush_next_ready: got %b want 1", inst_req_ready); end
    exp_ar.push_back('{id: 4'd0, addr: 32'hBFC0_0380, size: 3'd2});
    exp_r.push_back('{is_data: 1'b0, drop: 1'b0, data: 32'h3C1A_8000});
    cyc();
    inst_req_valid = 1'b0;
    do_axi(0, 1, 32'h3C1A_8000, -1, oa, st, rr, ni, nd, od);
    pop_exp(ea, er, ok);
    n_checks++;
    if (!ok || oa !== ea) begin n_fail++; $display("FAIL fflush_next_ar: got %h want %h", oa, ea); end
    n_checks++;
    if (ni != 1 || od !== er.data)
      begin n_fail++; $display("FAIL fflush_next_resp: got %0d/%h want 1/%h", ni, od, er.data); end
  endtask

  task automatic test_reset_mid();
    ar_t oa, ea; r_t er; bit ok, st, rr; int ni, nd; logic [31:0] od;
    inst_req_valid = 1'b1; inst_req_addr = 32'hBFC0_0008;
    cyc();
    inst_req_valid = 1'b0;
    #1;
    n_checks++;
    if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ar: got arvalid %b want 1", arvalid); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_ar.delete(); exp_r.delete(); mdl_last_data = 1'b0;
    #1;
    n_checks++;
    if ({arvalid, rready} !== 2'b00)
      begin n_fail++; $display("FAIL rmid_idle: got %b want 00", {arvalid, rready}); end
    data_req_valid = 1'b1; data_req_addr = 32'h8000_0040; data_req_size = 3'd1;
    #1;
    n_checks++;
    if (data_req_ready !== 1'b1)
      begin n_fail++; $display("FAIL rmid_fresh_ready: got %b want 1", data_req_ready); end
    exp_ar.push_back('{id: 4'd1, addr: 32'h8000_0040, size: 3'd1});
    exp_r.push_back('{is_data: 1'b1, drop: 1'b0, data: 32'h0000_BEEF});
    mdl_last_data = 1'b1;
    cyc();
    data_req_valid = 1'b0;
    do_axi(0, 0, 32'h0000_BEEF, -1, oa, st, rr, ni, nd, od);
    pop_exp(ea, er, ok);
    n_checks++;
    if (!ok || oa !== ea) begin n_fail++; $display("FAIL rmid_ar: got %h want %h", oa, ea); end
    n_checks++;
    if (nd != 1 || od !== er.data)
      begin n_fail++; $display("FAIL rmid_resp: got %0d/%h want 1/%h", nd, od, er.data); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous(32'hBFC0_0004, 32'h8000_0010, 32'h0000_0021, 32'h0000_00A5);
    test_ar_stall();
    test_data_flush();
    test_simultaneous(32'hBFC0_0200, 32'h8000_0030, 32'h2409_0002, 32'h0000_005A);
    test_fetch_flush();
    test_reset_mid();
    n_checks++;
    if (exp_ar.size() != 0 || exp_r.size() != 0)
      begin n_fail++; $display("FAIL sb_leftover: got %0d/%0d want 0/0", exp_ar.size(), exp_r.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
